// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcode, ALU select, FSM state and flag definitions
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_CLA = 4'd3;
  localparam logic [3:0] OP_CLE = 4'd4;
  localparam logic [3:0] OP_CMA = 4'd5;
  localparam logic [3:0] OP_CME = 4'd6;
  localparam logic [3:0] OP_CIR = 4'd7;
  localparam logic [3:0] OP_CIL = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;

  localparam logic [2:0] SEL_IDLE    = 3'd0;
  localparam logic [2:0] SEL_ADD     = 3'd1;
  localparam logic [2:0] SEL_AND     = 3'd2;
  localparam logic [2:0] SEL_PASS_DR = 3'd3;
  localparam logic [2:0] SEL_NOT_AC  = 3'd4;
  localparam logic [2:0] SEL_SHR     = 3'd5;
  localparam logic [2:0] SEL_SHL     = 3'd6;

  localparam int FLAG_CO  = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_N   = 1;
  localparam int FLAG_Z   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_EXEC = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

  // CLA/CLE/CME touch only AC/E directly and leave flags alone
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_INC) && (op != OP_CLA) && (op != OP_CLE) && (op != OP_CME);
  endfunction

  function automatic logic [2:0] alu_sel_for(input logic [3:0] op);
    case (op)
      OP_AND:  return SEL_AND;
      OP_ADD:  return SEL_ADD;
      OP_LDA:  return SEL_PASS_DR;
      OP_CMA:  return SEL_NOT_AC;
      OP_CIR:  return SEL_SHR;
      OP_CIL:  return SEL_SHL;
      OP_INC:  return SEL_ADD;
      default: return SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - decoder, memory and ALU signals around the sequencer
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [AW-1:0]    op_addr;
  logic             op_done;
  logic             op_err;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] alu_ac;
  logic [WIDTH-1:0] alu_dr;
  logic             alu_e;
  logic [2:0]       alu_select;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_q;

  modport slave (
    input  op_valid, op_code, op_addr, mem_rdata, mem_rvalid,
           alu_out, alu_carry, alu_flags,
    output op_ready, op_done, op_err, mem_rd, mem_addr,
           alu_ac, alu_dr, alu_e, alu_select, flags_q
  );

  modport master (
    output op_valid, op_code, op_addr, mem_rdata, mem_rvalid,
           alu_out, alu_carry, alu_flags,
    input  op_ready, op_done, op_err, mem_rd, mem_addr,
           alu_ac, alu_dr, alu_e, alu_select, flags_q
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-op-at-a-time sequencer owning AC/DR/E for an external ALU
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic             e_q, e_d;
  logic [3:0]       flags_q, flags_d;
  logic [2:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      addr_q  <= '0;
      ac_q    <= '0;
      dr_q    <= '0;
      e_q     <= 1'b0;
      flags_q <= '0;
      sel_q   <= SEL_IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
      flags_q <= flags_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // alu_select is registered, so it is computed on the transition into EXEC
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    e_d     = e_q;
    flags_d = flags_q;
    sel_d   = SEL_IDLE;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          op_d   = bus.op_code;
          addr_d = bus.op_addr;
          err_d  = 1'b0;
          if (is_mem_op(bus.op_code)) begin
            state_d = ST_RD;
          end else if (bus.op_code <= OP_INC) begin
            state_d = ST_EXEC;
            sel_d   = alu_sel_for(bus.op_code);
            if (bus.op_code == OP_INC) dr_d = WIDTH'(1);
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_RD: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      // read data arriving in the expiry cycle still counts as success
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          dr_d    = bus.mem_rdata;
          state_d = ST_EXEC;
          sel_d   = alu_sel_for(op_q);
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_AND, OP_LDA, OP_CMA: ac_d = bus.alu_out;
          OP_ADD, OP_INC: begin
            ac_d = bus.alu_out;
            e_d  = bus.alu_carry;
          end
          OP_CIR: begin
            ac_d = bus.alu_out;
            e_d  = ac_q[0];
          end
          OP_CIL: begin
            ac_d = bus.alu_out;
            e_d  = ac_q[WIDTH-1];
          end
          OP_CLA:  ac_d = '0;
          OP_CLE:  e_d  = 1'b0;
          OP_CME:  e_d  = ~e_q;
          default: ;
        endcase
        if (is_alu_op(op_q)) begin
          flags_d = {e_d, bus.alu_flags[FLAG_OVF], bus.alu_flags[FLAG_N], bus.alu_flags[FLAG_Z]};
        end
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.op_ready   = (state_q == ST_IDLE);
  assign bus.op_done    = (state_q == ST_DONE);
  assign bus.op_err     = (state_q == ST_DONE) && err_q;
  assign bus.mem_rd     = (state_q == ST_RD);
  assign bus.mem_addr   = addr_q;
  assign bus.alu_ac     = ac_q;
  assign bus.alu_dr     = dr_q;
  assign bus.alu_e      = e_q;
  assign bus.alu_select = sel_q;
  assign bus.flags_q    = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized bench with ALU, variable-latency memory and reference model
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int WIDTH   = 16;
  localparam int AW      = 12;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;

  alu_op_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU sitting beside the sequencer
  logic [16:0] alu_sum;
  logic        alu_ovf;
  always_comb begin
    alu_sum       = '0;
    alu_ovf       = 1'b0;
    bus.alu_out   = '0;
    bus.alu_carry = 1'b0;
    case (bus.alu_select)
      SEL_ADD: begin
        alu_sum       = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
        bus.alu_out   = alu_sum[15:0];
        bus.alu_carry = alu_sum[16];
        alu_ovf       = (bus.alu_ac[15] == bus.alu_dr[15]) && (alu_sum[15] != bus.alu_ac[15]);
      end
      SEL_AND:     bus.alu_out = bus.alu_ac & bus.alu_dr;
      SEL_PASS_DR: bus.alu_out = bus.alu_dr;
      SEL_NOT_AC:  bus.alu_out = ~bus.alu_ac;
      SEL_SHR:     bus.alu_out = {bus.alu_e, bus.alu_ac[15:1]};
      SEL_SHL:     bus.alu_out = {bus.alu_ac[14:0], bus.alu_e};
      default:     bus.alu_out = '0;
    endcase
    bus.alu_flags = {bus.alu_carry, alu_ovf, bus.alu_out[15], bus.alu_out == 16'h0000};
  end

  // Memory with per-op latency: rvalid lands mem_lat cycles after the mem_rd cycle
  logic [15:0] mem [16];
  int          mem_lat = 1;
  int          pending = 0;
  logic [3:0]  rd_addr;
  int          rd_cnt  = 0;
  logic [2:0]  sel_seen;

  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'($urandom);
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem[rd_addr];
        end
      end
      if (bus.mem_rd) begin
        pending = mem_lat;
        rd_addr = bus.mem_addr[3:0];
        rd_cnt++;
      end
      if (bus.alu_select != 3'd0) sel_seen = bus.alu_select;
    end
  end

  logic [15:0] m_ac, m_dr;
  logic        m_e;
  logic [3:0]  m_flags;
  int          sel_tab [10] = '{2, 1, 3, 0, 0, 4, 0, 5, 6, 1};

  function automatic int to_signed16(input logic [15:0] v);
    return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
  endfunction

  // Caller must be at a negedge; returns at the negedge of the op_done cycle
  task automatic do_op(input logic [3:0] code, input logic [3:0] addr, input int lat, input bit hold);
    logic [15:0] data, nac, ndr;
    logic        ne, ovf, exp_err;
    logic [3:0]  nfl;
    int          exp_lat, cyc, sres;
    bit          got, is_mem;

    data    = mem[addr];
    is_mem  = (code <= 4'd2);
    nac     = m_ac;
    ndr     = m_dr;
    ne      = m_e;
    nfl     = m_flags;
    ovf     = 1'b0;
    exp_err = 1'b0;
    if (code > 4'd9) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (is_mem && lat > TIMEOUT + 1) begin
      exp_err = 1'b1;
      exp_lat = TIMEOUT + 3;
    end else begin
      exp_lat = is_mem ? 3 + lat : 2;
      if (is_mem) ndr = data;
      if (code == 4'd9) ndr = 16'd1;
      case (code)
        4'd0: nac = m_ac & data;
        4'd1, 4'd9: begin
          sres = int'(m_ac) + int'(ndr);
          nac  = 16'(sres % 65536);
          ne   = (sres >= 65536);
          sres = to_signed16(m_ac) + to_signed16(ndr);
          ovf  = (sres > 32767) || (sres < -32768);
        end
        4'd2: nac = data;
        4'd3: nac = 16'd0;
        4'd4: ne = 1'b0;
        4'd5: nac = 16'(65535 - int'(m_ac));
        4'd6: ne = ~m_e;
        4'd7: begin
          nac = 16'(int'(m_ac) / 2 + (m_e ? 32768 : 0));
          ne  = m_ac[0];
        end
        4'd8: begin
          nac = 16'((int'(m_ac) * 2) % 65536 + (m_e ? 1 : 0));
          ne  = (m_ac >= 16'h8000);
        end
        default: ;
      endcase
      if (code != 4'd3 && code != 4'd4 && code != 4'd6)
        nfl = {ne, ovf, nac >= 16'h8000, nac == 16'd0};
    end

    mem_lat      = lat;
    sel_seen     = 3'd0;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_addr  = AW'(addr);
    cyc = 0;
    while (!bus.op_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_wait", 32'(cyc < 50), 32'd1);
    @(negedge clk);
    if (hold) bus.op_code = 4'd13;
    else bus.op_valid = 1'b0;
    cyc = 1;
    got = 0;
    while (cyc < 60) begin
      if (bus.op_done) begin
        got = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("op_done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("op_err", 32'(bus.op_err), 32'(exp_err));
    check("ac", 32'(bus.alu_ac), 32'(nac));
    check("dr", 32'(bus.alu_dr), 32'(ndr));
    check("e", 32'(bus.alu_e), 32'(ne));
    check("flags", 32'(bus.flags_q), 32'(nfl));
    check("alu_select", 32'(sel_seen), exp_err ? 32'd0 : 32'(sel_tab[code]));
    if (is_mem) check("mem_addr", 32'(bus.mem_addr), 32'(addr));
    m_ac    = nac;
    m_dr    = ndr;
    m_e     = ne;
    m_flags = nfl;
  endtask

  initial begin
    int rd0, dones;
    logic [3:0] code;

    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[1] = 16'h7FFF;
    mem[2] = 16'h0001;
    mem[3] = 16'h8001;
    mem[4] = 16'hFFFF;
    bus.op_valid = 1'b0;
    bus.op_code  = '0;
    bus.op_addr  = '0;
    m_ac = '0; m_dr = '0; m_e = 1'b0; m_flags = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ac", 32'(bus.alu_ac), 32'd0);
    check("rst_dr", 32'(bus.alu_dr), 32'd0);
    check("rst_e", 32'(bus.alu_e), 32'd0);
    check("rst_flags", 32'(bus.flags_q), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_select", 32'(bus.alu_select), 32'd0);
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_done", 32'(bus.op_done), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);

    do_op(OP_LDA, 4'd1, 2, 0);
    do_op(OP_ADD, 4'd2, 3, 0);
    check("add_ac_8000", 32'(bus.alu_ac), 32'h8000);
    check("add_flags_0110", 32'(bus.flags_q), 32'b0110);

    do_op(OP_LDA, 4'd3, 1, 0);
    do_op(OP_CLE, 4'd0, 0, 0);
    rd0 = rd_cnt;
    do_op(OP_CIL, 4'd0, 0, 0);
    check("cil_ac", 32'(bus.alu_ac), 32'h0002);
    check("cil_e", 32'(bus.alu_e), 32'd1);
    check("cil_no_rd", 32'(rd_cnt - rd0), 32'd0);

    do_op(OP_LDA, 4'd4, 1, 0);
    do_op(OP_INC, 4'd0, 0, 0);
    check("inc_z", 32'(bus.flags_q[0]), 32'd1);
    do_op(OP_CME, 4'd0, 0, 0);
    check("cme_e", 32'(bus.alu_e), 32'd0);

    do_op(OP_LDA, 4'd5, TIMEOUT + 5, 0);
    do_op(OP_LDA, 4'd6, TIMEOUT + 1, 0);
    do_op(4'd12, 4'd0, 0, 0);

    // reset while waiting on memory, read data arrives afterwards
    mem_lat      = 8;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_LDA;
    bus.op_addr  = AW'(7);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.op_done) dones++;
    end
    check("rstw_no_done", 32'(dones), 32'd0);
    check("rstw_ready", 32'(bus.op_ready), 32'd1);
    check("rstw_ac", 32'(bus.alu_ac), 32'd0);
    check("rstw_dr", 32'(bus.alu_dr), 32'd0);
    check("rstw_e", 32'(bus.alu_e), 32'd0);
    m_ac = '0; m_dr = '0; m_e = 1'b0; m_flags = '0;

    rd0 = rd_cnt;
    do_op(OP_ADD, 4'd8, 2, 1);
    do_op(OP_CMA, 4'd0, 0, 1);
    do_op(OP_LDA, 4'd9, 4, 1);
    bus.op_valid = 1'b0;
    check("b2b_rd_count", 32'(rd_cnt - rd0), 32'd2);

    for (int i = 0; i < 60; i++) begin
      code = 4'($urandom_range(0, 15));
      if (code > 4'd9 && $urandom_range(0, 2) != 0) code = 4'($urandom_range(0, 9));
      do_op(code, 4'($urandom_range(0, 15)), $urandom_range(1, TIMEOUT + 4), 1'($urandom_range(0, 1)));
    end
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
